seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 17 +
 rtl/SEG7_LUT.sv | 30 +++
 rtl/seg7_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the four-digit multiplexed 7-segment scanner.
//   state_e    : scan FSM states (BLANK dead-time, ON digit driven)
//   NUM_DIGITS : digits in the display
//   SEG_BLANK  : all segments off (active-low)
//   SEG_DASH   : only segment g lit, shown for non-BCD digit values
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_e;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;

endpackage

// File: rtl/SEG7_LUT.sv
// Hex digit to active-low 7-segment decoder.
//   iDIG : 4-bit digit value
//   oSEG : segments {g,f,e,d,c,b,a}, active-low
module SEG7_LUT (
    input  logic [3:0] iDIG,
    output logic [6:0] oSEG
);

    always_comb begin
        unique case (iDIG)
            4'h0: oSEG = 7'b1000000;
            4'h1: oSEG = 7'b1111001;
            4'h2: oSEG = 7'b0100100;
            4'h3: oSEG = 7'b0110000;
            4'h4: oSEG = 7'b0011001;
            4'h5: oSEG = 7'b0010010;
            4'h6: oSEG = 7'b0000010;
            4'h7: oSEG = 7'b1111000;
            4'h8: oSEG = 7'b0000000;
            4'h9: oSEG = 7'b0011000;
            4'hA: oSEG = 7'b0001000;
            4'hB: oSEG = 7'b0000011;
            4'hC: oSEG = 7'b1000110;
            4'hD: oSEG = 7'b0100001;
            4'hE: oSEG = 7'b0000110;
            4'hF: oSEG = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-aligned
// double buffering. New data is taken into a hold register through a
// ready/load handshake and copied to the displayed shadow register only at
// a frame boundary, so a frame never shows a mix of old and new digits.
//   iCLK, iRST : clock, asynchronous active-high reset
//   iDATA      : four BCD digits, [3:0] is the rightmost digit
//   iLOAD      : load request, taken only while oREADY=1
//   iLZB       : leading-zero blanking enable (live)
//   oREADY     : no load pending
//   oAN        : digit enables, active-low
//   oSEG       : segments, active-low
//   oFRAME     : one-cycle pulse on each frame boundary
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iDATA,
    input  logic        iLOAD,
    input  logic        iLZB,
    output logic        oREADY,
    output logic [3:0]  oAN,
    output logic [6:0]  oSEG,
    output logic        oFRAME
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    // Counter only ever reaches MAX_CYC-1; keep at least one bit.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         dig_q, dig_d;
    logic [15:0]        shadow_q, hold_q;
    logic               pending_q;

    logic               tc;
    logic               frame;
    logic               accept;
    logic [3:0]         cur_dig;
    logic [6:0]         lut_seg;
    logic [NUM_DIGITS-1:0] nz;
    logic               lz_blank;

    assign tc = (state_q == BLANK) ? (cnt_q == CNT_W'(BLANK_CYC - 1))
                                   : (cnt_q == CNT_W'(ON_CYC - 1));
    assign frame  = (state_q == BLANK) && tc && (dig_q == 2'd0);
    assign accept = iLOAD && !pending_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        dig_d   = dig_q;
        if (tc) begin
            cnt_d = '0;
            if (state_q == BLANK) begin
                state_d = ON;
            end else begin
                state_d = BLANK;
                dig_d   = dig_q + 2'd1;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= BLANK;
            cnt_q     <= '0;
            dig_q     <= '0;
            shadow_q  <= '0;
            hold_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            // Commit uses the pending flag from before this edge, so a load
            // accepted in the boundary cycle waits for the next boundary.
            if (frame && pending_q) begin
                shadow_q  <= hold_q;
                pending_q <= 1'b0;
            end else if (accept) begin
                hold_q    <= iDATA;
                pending_q <= 1'b1;
            end
        end
    end

    assign cur_dig = shadow_q[dig_q*4 +: 4];

    SEG7_LUT u_lut (
        .iDIG (cur_dig),
        .oSEG (lut_seg)
    );

    // Digit d>=1 is a leading zero when it and every higher digit are zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) nz[i] = |shadow_q[i*4 +: 4];
        lz_blank = iLZB && (dig_q != 2'd0);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(dig_q) && nz[i]) lz_blank = 1'b0;
        end
    end

    // Overrides sit after the decoder so its non-BCD codes never leak out.
    always_comb begin
        oAN  = '1;
        oSEG = SEG_BLANK;
        if (state_q == ON && !lz_blank) begin
            oAN[dig_q] = 1'b0;
            oSEG       = (cur_dig > 4'd9) ? SEG_DASH : lut_seg;
        end
    end

    assign oREADY = !pending_q;
    assign oFRAME = frame;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S7 = 7'b1111000,
                           S9 = 7'b0011000, SD = 7'b0111111, SB = 7'b1111111;
    localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic        load = 1'b0;
    logic        lzb = 1'b0;
    logic        ready;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(.ON_CYC(4), .BLANK_CYC(2)) dut (
        .iCLK   (clk),
        .iRST   (rst),
        .iDATA  (data),
        .iLOAD  (load),
        .iLZB   (lzb),
        .oREADY (ready),
        .oAN    (an),
        .oSEG   (seg),
        .oFRAME (frame)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until oFRAME is seen; returns the number of steps taken.
    task automatic wait_frame(input string tag, output int n);
        n = 0;
        while (frame !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_seen"}, {15'd0, frame}, 16'd1);
    endtask

    // Called while sitting on a frame cycle; walks the 24 cycles of the next
    // frame and finishes on its closing frame cycle. Position p: digit p/6,
    // driven for p%6 < 4. ld_p is an accepted load, ig_p one that must be
    // ignored; busy means a load is already pending for the whole frame.
    task automatic check_frame(input string tag,
                               input logic [3:0][6:0] seg_e,
                               input logic [3:0][3:0] an_e,
                               input bit busy,
                               input int ld_p, input logic [15:0] ld_d,
                               input int ig_p, input logic [15:0] ig_d);
        step();
        for (int p = 0; p < 24; p++) begin
            int  k;
            bit  on;
            bit  rdy;
            k   = p / 6;
            on  = (p % 6) < 4;
            rdy = !busy && (ld_p < 0 || p <= ld_p);
            chk($sformatf("%s_an_p%0d", tag, p),  {12'd0, an},  {12'd0, on ? an_e[k] : 4'b1111});
            chk($sformatf("%s_seg_p%0d", tag, p), {9'd0, seg},  {9'd0, on ? seg_e[k] : SB});
            chk($sformatf("%s_frm_p%0d", tag, p), {15'd0, frame}, {15'd0, p == 23});
            chk($sformatf("%s_rdy_p%0d", tag, p), {15'd0, ready}, {15'd0, rdy});
            if (p == ld_p) begin load = 1'b1; data = ld_d; end
            if (p == ig_p) begin load = 1'b1; data = ig_d; end
            if (p != 23) begin
                step();
                load = 1'b0;
            end
        end
    endtask

    initial begin
        int n;
        // Reset held: outputs blank, ready, no frame pulse.
        step(); step();
        chk("rst_an",    {12'd0, an},    16'h000F);
        chk("rst_seg",   {9'd0, seg},    16'h007F);
        chk("rst_rdy",   {15'd0, ready}, 16'd1);
        chk("rst_frame", {15'd0, frame}, 16'd0);
        rst = 1'b0;

        // First boundary is in the second BLANK cycle after release.
        wait_frame("first", n);
        chk("first_lat", n[15:0], 16'd1);

        // Idle frame of zeros.
        check_frame("f1", {S0, S0, S0, S0}, AN_ALL, 1'b0, -1, '0, -1, '0);
        // Load 1234 mid-frame; a second load while busy is ignored.
        check_frame("f2", {S0, S0, S0, S0}, AN_ALL, 1'b0, 5, 16'h1234, 10, 16'h5678);
        // 1234 shown; load 9999 in the closing boundary cycle.
        check_frame("f3", {S1, S2, S3, S4}, AN_ALL, 1'b0, 23, 16'h9999, -1, '0);
        // 9999 still pending: 1234 remains for this whole frame.
        check_frame("f4", {S1, S2, S3, S4}, AN_ALL, 1'b1, -1, '0, -1, '0);
        // 9999 shown; queue 00A7 and enable leading-zero blanking.
        lzb = 1'b1;
        check_frame("f5", {S9, S9, S9, S9}, AN_ALL, 1'b0, 3, 16'h00A7, -1, '0);
        // Digits 3,2 blanked, digit 1 dash, digit 0 shows 7.
        check_frame("f6", {SB, SB, SD, S7}, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    1'b0, -1, '0, -1, '0);

        // Mid-frame reset with a load pending.
        step(); step(); step();
        load = 1'b1; data = 16'h5555;
        step();
        load = 1'b0;
        chk("pend_rdy", {15'd0, ready}, 16'd0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_an",  {12'd0, an},    16'h000F);
        chk("mrst_seg", {9'd0, seg},    16'h007F);
        chk("mrst_rdy", {15'd0, ready}, 16'd1);
        step(); step();
        rst = 1'b0;
        wait_frame("after", n);
        chk("after_lat", n[15:0], 16'd1);
        // Leading-zero blanking on 0000 still shows digit 0.
        check_frame("f7", {SB, SB, SB, S0}, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    1'b0, -1, '0, -1, '0);
        lzb = 1'b0;
        // Discarded load never commits.
        check_frame("f8", {S0, S0, S0, S0}, AN_ALL, 1'b0, -1, '0, -1, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
